// File: rtl/hs_rr_arbiter_pkg.sv
// ============================================================================
// Module  : hs_rr_arbiter_pkg
// Brief   : FSM state encodings and width helper for the round-robin
//           4-phase handshake arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hs_rr_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_REQ     = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Smallest r with 2**r >= value; used for elaboration-time widths only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs_rr_arbiter_rr_pick.sv
// ============================================================================
// Module  : hs_rr_arbiter_rr_pick
// Brief   : Combinational rotating-priority picker: first set request bit
//           scanning upward from ptr with wrap-around.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_rr_arbiter_rr_pick
    import hs_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] index,
    output logic          valid
);

    localparam logic [PW:0] c_n_ext = (PW + 1)'(N);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_pos;

    // ptr is always < N, so ptr + i < 2N and one conditional subtract wraps it.
    always_comb begin
        gnt   = '0;
        index = '0;
        valid = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr} + (PW + 1)'(i);
            if (w_sum >= c_n_ext) begin
                w_sum = w_sum - c_n_ext;
            end
            w_pos = w_sum[PW-1:0];
            if (!valid && req[w_pos]) begin
                valid      = 1'b1;
                gnt[w_pos] = 1'b1;
                index      = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hs_rr_arbiter.sv
// ============================================================================
// Module  : hs_rr_arbiter
// Brief   : Clocked round-robin arbiter sharing one 4-phase handshake
//           resource among N requesters, with acknowledge timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_rr_arbiter
    import hs_rr_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] ack_o,
    output logic [N-1:0] grant_o,
    output logic         res_req_o,
    input  logic         res_ack_i,
    output logic         timeout_o,
    output logic         busy_o
);

    localparam int            PW         = clog2(N);
    localparam int            CW         = clog2(TIMEOUT);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] c_ptr_last = PW'(N - 1);

    state_t        state_q,   state_d;
    logic [PW-1:0] ptr_q,     ptr_d;
    logic [PW-1:0] owner_q,   owner_d;
    logic [N-1:0]  grant_q,   grant_d;
    logic [N-1:0]  ack_q,     ack_d;
    logic          res_req_q, res_req_d;
    logic          timeout_q, timeout_d;
    logic          busy_q,    busy_d;
    logic [CW-1:0] cnt_q,     cnt_d;

    logic [N-1:0]  w_pick_gnt;
    logic [PW-1:0] w_pick_idx;
    logic          w_pick_valid;

    hs_rr_arbiter_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .gnt   (w_pick_gnt),
        .index (w_pick_idx),
        .valid (w_pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        ack_d     = ack_q;
        res_req_d = res_req_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    state_d = ST_GRANT;
                    grant_d = w_pick_gnt;
                    owner_d = w_pick_idx;
                end
            end
            ST_GRANT: begin
                state_d   = ST_REQ;
                res_req_d = 1'b1;
                cnt_d     = '0;
                ptr_d     = (owner_q == c_ptr_last) ? '0 : owner_q + PW'(1);
            end
            ST_REQ: begin
                if (res_ack_i) begin
                    state_d = ST_ACK;
                    ack_d   = grant_q;
                end else if (cnt_q == c_cnt_last) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                    res_req_d = 1'b0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACK: begin
                // Only the owner's request line matters; others are ignored.
                if ((req_i & grant_q) == '0) begin
                    state_d   = ST_RELEASE;
                    ack_d     = '0;
                    res_req_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!res_ack_i) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = '0;
                ack_d     = '0;
                res_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            res_req_q <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            res_req_q <= res_req_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack_o     = ack_q;
    assign grant_o   = grant_q;
    assign res_req_o = res_req_q;
    assign timeout_o = timeout_q;
    assign busy_o    = busy_q;

endmodule

`default_nettype wire
